// File: rtl/seven_seg_pkg.sv
// Shared seven-segment constants and helpers for the switch/hex display slice.
// Segment vectors are ordered gfedcba and are active-low.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Validity rule selectors
    localparam int VALID_ALL   = 0;
    localparam int VALID_POP02 = 1;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus whole-vector debounce for a switch bank.
// dout follows din once the synchronised value has held for DEB_CYCLES samples.
module switch_debounce #(
    parameter int W          = 8,
    parameter int DEB_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         upd
);

    localparam int          CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DEB_CYCLES - 2);

    logic [W-1:0]  sync1_q, sync1_d;
    logic [W-1:0]  sync2_q, sync2_d;
    logic [W-1:0]  cand_q,  cand_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [W-1:0]  dout_q,  dout_d;
    logic          upd_q,   upd_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        upd_d   = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else begin
            // Saturate so a long-held value cannot wrap into a second accept.
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (cnt_q == CNT_PRE && cand_q != dout_q) begin
                dout_d = cand_q;
                upd_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            upd_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            upd_q   <= upd_d;
        end
    end

    assign dout = dout_q;
    assign upd  = upd_q;

endmodule

// File: rtl/switch_hex_display.sv
// Debounced switch bank shown as hex on a multiplexed active-low 7-seg display.
// Invalid patterns replace the readout with a blinking "Er".
module switch_hex_display
    import seven_seg_pkg::*;
#(
    parameter int NSW          = 8,
    parameter int DEB_CYCLES   = 500000,
    parameter int SCAN_CYCLES  = 50000,
    parameter int BLINK_CYCLES = 12500000,
    parameter int VALID_MODE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSW-1:0]    slide_switch,
    output logic [NSW-1:0]    ledout,
    output logic [6:0]        seg,
    output logic [NSW/4-1:0]  an,
    output logic              err,
    output logic              upd
);

    localparam int NDIG = NSW / 4;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int SCW  = $clog2(SCAN_CYCLES);
    localparam int BCW  = $clog2(BLINK_CYCLES);

    localparam logic [IW-1:0]  IDX_LAST   = IW'(NDIG - 1);
    localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_CYCLES - 1);
    localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_CYCLES - 1);

    logic [NSW-1:0]  led;
    logic            led_upd;

    logic            err_q,       err_d;
    logic [SCW-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [IW-1:0]   idx_q,       idx_d;
    logic [BCW-1:0]  blink_cnt_q, blink_cnt_d;
    logic            blink_off_q, blink_off_d;
    logic [6:0]      seg_q,       seg_d;
    logic [NDIG-1:0] an_q,        an_d;

    logic [4:0]      pop;
    logic            valid;
    logic [3:0]      nib;

    switch_debounce #(
        .W          (NSW),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (slide_switch),
        .dout (led),
        .upd  (led_upd)
    );

    always_comb begin
        pop = '0;
        for (int i = 0; i < NSW; i++) begin
            pop = pop + 5'(led[i]);
        end
        valid = (VALID_MODE == VALID_ALL) || (pop == 5'd0) || (pop == 5'd2);
        err_d = ~valid;
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCW'(1);
        idx_d      = idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // Holding the blink timer clear while err is low makes every error
    // episode start in the visible phase and leave no residue when it ends.
    always_comb begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
        if (err_q) begin
            blink_cnt_d = blink_cnt_q + BCW'(1);
            blink_off_d = blink_off_q;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end
        end
    end

    always_comb begin
        nib = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (idx_q == IW'(k)) begin
                nib = led[4*k +: 4];
            end
        end

        seg_d = hex_to_seg(nib);
        if (err_q) begin
            if (blink_off_q) begin
                seg_d = SEG_BLANK;
            end else if (NDIG == 1) begin
                seg_d = SEG_E;
            end else if (idx_q == IW'(1)) begin
                seg_d = SEG_E;
            end else if (idx_q == IW'(0)) begin
                seg_d = SEG_R;
            end else begin
                seg_d = SEG_BLANK;
            end
        end

        an_d = ~(NDIG'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q       <= 1'b0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            seg_q       <= SEG_BLANK;
            an_q        <= '1;
        end else begin
            err_q       <= err_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign ledout = led;
    assign upd    = led_upd;
    assign err    = err_q;
    assign seg    = seg_q;
    assign an     = an_q;

endmodule

// File: tb/tb_switch_hex_display.sv
// Self-checking bench: two instances (popcount rule and all-valid) share one
// switch input and are compared each cycle against a behavioural model.
module tb_switch_hex_display;

    localparam int NSW   = 8;
    localparam int NDIG  = 2;
    localparam int DEB   = 4;
    localparam int SCAN  = 3;
    localparam int BLINK = 8;

    localparam logic [6:0] HEX_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] S_E     = 7'b0000110;
    localparam logic [6:0] S_R     = 7'b0101111;
    localparam logic [6:0] S_BLANK = 7'b1111111;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NSW-1:0] sw  = '0;

    logic [NSW-1:0]  led1, led0;
    logic [6:0]      seg1, seg0;
    logic [NDIG-1:0] an1, an0;
    logic            err1, err0, upd1, upd0;

    int errors = 0;
    int checks = 0;

    switch_hex_display #(
        .NSW(NSW), .DEB_CYCLES(DEB), .SCAN_CYCLES(SCAN),
        .BLINK_CYCLES(BLINK), .VALID_MODE(1)
    ) dut_m1 (
        .clk(clk), .rst(rst), .slide_switch(sw), .ledout(led1),
        .seg(seg1), .an(an1), .err(err1), .upd(upd1)
    );

    switch_hex_display #(
        .NSW(NSW), .DEB_CYCLES(DEB), .SCAN_CYCLES(SCAN),
        .BLINK_CYCLES(BLINK), .VALID_MODE(0)
    ) dut_m0 (
        .clk(clk), .rst(rst), .slide_switch(sw), .ledout(led0),
        .seg(seg0), .an(an0), .err(err0), .upd(upd0)
    );

    always #5 clk = ~clk;

    // Reference state: the value the display should hold after each edge.
    logic [NSW-1:0]  hist [$];
    logic [NSW-1:0]  run_val;
    int              run_len;
    int              cyc;
    int              idx_m;
    logic [NSW-1:0]  led_m;
    logic            upd_m;
    logic            err_m [2];
    int              age_m [2];
    logic [6:0]      seg_m [2];
    logic [NDIG-1:0] an_m;

    function automatic logic invalid(input int mode, input logic [NSW-1:0] v);
        int ones = 0;
        for (int i = 0; i < NSW; i++) ones += int'(v[i]);
        if (mode == 0) return 1'b0;
        return !(ones == 0 || ones == 2);
    endfunction

    function automatic logic [6:0] disp(input int m);
        if (err_m[m]) begin
            if (((age_m[m] / BLINK) % 2) == 1) return S_BLANK;
            if (idx_m == 1) return S_E;
            if (idx_m == 0) return S_R;
            return S_BLANK;
        end
        return HEX_TAB[int'((led_m >> (4 * idx_m)) & 8'h0f)];
    endfunction

    task automatic model_edge(input logic [NSW-1:0] v, input logic r);
        logic [NSW-1:0] view;
        logic           e_new;
        if (r) begin
            hist.delete();
            run_val = '0;
            run_len = 1;
            cyc     = 0;
            idx_m   = 0;
            led_m   = '0;
            upd_m   = 1'b0;
            an_m    = '1;
            for (int m = 0; m < 2; m++) begin
                err_m[m] = 1'b0;
                age_m[m] = 0;
                seg_m[m] = S_BLANK;
            end
            return;
        end
        an_m = ~(NDIG'(1) << idx_m);
        for (int m = 0; m < 2; m++) seg_m[m] = disp(m);
        // Pins reach the debounce compare two samples late.
        hist.push_back(v);
        view = (hist.size() >= 3) ? hist[hist.size() - 3] : '0;
        if (hist.size() > 3) void'(hist.pop_front());
        if (view == run_val) run_len++;
        else begin
            run_val = view;
            run_len = 1;
        end
        for (int m = 0; m < 2; m++) begin
            e_new    = invalid(m, led_m);
            age_m[m] = (e_new && err_m[m]) ? age_m[m] + 1 : 0;
            err_m[m] = e_new;
        end
        upd_m = 1'b0;
        if (run_len == DEB && run_val != led_m) begin
            led_m = run_val;
            upd_m = 1'b1;
        end
        cyc++;
        idx_m = (cyc / SCAN) % NDIG;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [NSW-1:0] v, input logic r);
        sw  = v;
        rst = r;
        @(posedge clk);
        model_edge(v, r);
        #1;
        chk("ledout_m1", 32'(led1), 32'(led_m));
        chk("ledout_m0", 32'(led0), 32'(led_m));
        chk("upd_m1",    32'(upd1), 32'(upd_m));
        chk("upd_m0",    32'(upd0), 32'(upd_m));
        chk("err_m1",    32'(err1), 32'(err_m[1]));
        chk("err_m0",    32'(err0), 32'(err_m[0]));
        chk("seg_m1",    32'(seg1), 32'(seg_m[1]));
        chk("seg_m0",    32'(seg0), 32'(seg_m[0]));
        chk("an_m1",     32'(an1),  32'(an_m));
        chk("an_m0",     32'(an0),  32'(an_m));
    endtask

    initial begin
        int pulses;
        int blanks;
        logic [NSW-1:0] pick;
        logic [NSW-1:0] pool [6] = '{8'h00, 8'h03, 8'h81, 8'h07, 8'hFF, 8'h24};

        // Reset with switches at zero, then a few scan periods of "00".
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);
        chk("reset_an",  32'(an1),  32'h3);
        chk("reset_seg", 32'(seg1), 32'h7f);
        chk("reset_led", 32'(led1), 32'h0);
        for (int i = 0; i < 12; i++) step(8'h00, 1'b0);
        chk("zero_seg", 32'(seg1), 32'(7'b1000000));

        // 0x81 reaches ledout on the sixth edge after it is applied.
        pulses = 0;
        for (int i = 1; i <= 5; i++) begin
            step(8'h81, 1'b0);
            pulses += int'(upd1);
        end
        chk("deb_early", 32'(led1), 32'h00);
        step(8'h81, 1'b0);
        pulses += int'(upd1);
        chk("deb_accept", 32'(led1), 32'h81);
        for (int i = 0; i < 10; i++) begin
            step(8'h81, 1'b0);
            pulses += int'(upd1);
        end
        chk("upd_once", 32'(pulses), 32'd1);

        // Three-cycle glitch to 0x82 must be discarded.
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(8'h82, 1'b0);
            pulses += int'(upd1);
        end
        for (int i = 0; i < 10; i++) begin
            step(8'h81, 1'b0);
            pulses += int'(upd1);
        end
        chk("glitch_led", 32'(led1), 32'h81);
        chk("glitch_upd", 32'(pulses), 32'd0);

        // 0x07 is invalid under the popcount rule: blinking Er, then back to "03".
        blanks = 0;
        for (int i = 0; i < 45; i++) begin
            step(8'h07, 1'b0);
            if (err1 && seg1 == S_BLANK) blanks++;
        end
        chk("err_set_m1", 32'(err1), 32'd1);
        chk("err_clr_m0", 32'(err0), 32'd0);
        chk("blink_seen", 32'(blanks > 0), 32'd1);
        for (int i = 0; i < 20; i++) step(8'h03, 1'b0);
        chk("err_gone", 32'(err1), 32'd0);
        chk("led_03",   32'(led1), 32'h03);

        // Reset two cycles into debouncing 0xFF aborts it; a full window follows.
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b1);
        chk("midrst_led", 32'(led1), 32'h00);
        chk("midrst_an",  32'(an1),  32'h3);
        chk("midrst_seg", 32'(seg1), 32'h7f);
        for (int i = 1; i <= 5; i++) step(8'hFF, 1'b0);
        chk("midrst_early", 32'(led1), 32'h00);
        step(8'hFF, 1'b0);
        chk("midrst_accept", 32'(led1), 32'hFF);
        for (int i = 0; i < 24; i++) step(8'hFF, 1'b0);

        // Random hold lengths, including glitches shorter than the window.
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 3) == 0) pick = 8'($urandom);
            else pick = pool[$urandom_range(0, 5)];
            for (int i = 0, n = $urandom_range(1, 14); i < n; i++) step(pick, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_hex_display.md
Name: switch_hex_display

Overview:
Parametrised successor to the slide-switch decoder. Synchronises and debounces an NSW-bit switch bank and checks the pattern against a selectable validity rule. Shows the value as hex on a time-multiplexed, active-low seven-segment display, one digit per nibble. An invalid pattern shows a blinking "Er". Sits between board switch pins and the seven-segment/LED pins.

Parameters:
NSW, 8, switch count; multiple of 4, range 4..16; NDIG = NSW/4 digits (localparam)
DEB_CYCLES, 500000, consecutive stable cycles required to accept a new switch value (>=2)
SCAN_CYCLES, 50000, clock cycles each digit is enabled (>=2)
BLINK_CYCLES, 12500000, half-period of the error blink, in cycles (>=2)
VALID_MODE, 1, 0 = every pattern valid; 1 = valid only if popcount is 0 or 2

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
slide_switch  in  NSW  raw asynchronous switch inputs
ledout  out  NSW  debounced switch value
seg  out  7  segments gfedcba, active-low
an  out  NDIG  digit enables, active-low; bit 0 = rightmost digit
err  out  1  high while the debounced pattern is invalid
upd  out  1  one-cycle pulse when ledout changes

Behaviour:
- Reset, synchronous: ledout=0, err=0, upd=0, an=all 1, seg=7'b1111111. Scan index, scan counter, blink counter, debounce counter and synchroniser all clear. Reset asserted mid-operation aborts any debounce in progress.
- Synchroniser: 2 flops per bit.
- Debounce is on the whole vector. Candidate register compares with the synchroniser output. On mismatch: load candidate, clear counter. On match: increment counter.
- When the counter reaches DEB_CYCLES-1 and candidate != ledout: ledout <= candidate and upd=1 for that one cycle. A held pin change reaches ledout DEB_CYCLES+2 edges after the first sampling edge. Shorter glitches are discarded.
- Validity is combinational on ledout. Mode 1: valid iff popcount(ledout) is 0 or 2. err is registered, updates on the edge after ledout.
- Scan counter runs 0..SCAN_CYCLES-1. At the terminal count the index advances modulo NDIG (0,1,...,NDIG-1,0). seg and an are registered from the index, one cycle latency. Exactly one an bit is low at any time after the first post-reset edge.
- Normal digit k shows the hex of ledout[4k+3:4k]. Codes:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  r=0101111, blank=1111111
- Error display: digit1="E", digit0="r", higher digits blank. If NDIG==1, digit0="E".
- Blink counter clears on the rising edge of err, so the first phase is "on". Phase toggles every BLINK_CYCLES. In the off phase all seg=blank; an keeps scanning.
- Falling edge of err returns to normal display immediately, with no blink remnant.
- Simultaneous debounce accept and scan step: both take effect. The new digit shows the new value on the following cycle.

Decomposition:
- Package seven_seg_pkg: 7-bit segment constants (hex digits, E, r, blank), hex_to_seg function, VALID_MODE encodings.
- Sub-module switch_debounce: parameters W and DEB_CYCLES; contains the synchroniser, candidate register, counter and upd generation.
- Validity check, scan, blink and segment mux stay in the top level.

Test Plan:
All scenarios use NSW=8, DEB_CYCLES=4, SCAN_CYCLES=3, BLINK_CYCLES=8 unless noted.
1. Reset, switches 0x00 -> ledout=0, err=0. an alternates 2'b10/2'b01 every 3 cycles, seg=1000000 on both digits.
2. Switches 0x81 held -> ledout=0x81 exactly 6 edges after apply; upd pulses once. Digit1 seg=0000000, digit0 seg=1111001.
3. From 0x81, drive 0x82 for 3 cycles then back to 0x81 -> ledout stays 0x81, no upd pulse.
4. Switches 0x07 (VALID_MODE=1) -> err=1. Digit1=0000110, digit0=0101111 for 8 cycles, then all blank for 8 cycles, repeating. Switching to 0x03 -> err=0, display shows "03".
5. VALID_MODE=0, switches 0x07 -> err=0, digit1=1000000, digit0=1111000.
6. Assert rst 2 cycles into debouncing 0xFF -> next edge all outputs at reset values. After release, 0xFF is accepted only after a full new debounce window.
